ped_request_ctrl: RTL and testbench
===================================

Name: ped_request_ctrl

Overview:
Pedestrian push-button front end that sits directly upstream of the crossing light sequencer. It conditions the raw, asynchronous, bouncing button and latches a single pedestrian request. It holds that request towards the sequencer until the sequencer reports that the pedestrian phase is being served. It also drives the "WAIT" indicator lamp on the button housing and applies a short post-service lockout so a press during the walk phase does not immediately re-trigger the phase.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive cycles the synchronised button must differ from btn_clean before btn_clean follows it (legal range 2..255)
LOCKOUT_CYCLES, 8, duration of the LOCKOUT state in clock cycles after the pedestrian phase ends (legal range 1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
btn_raw  input  1  raw push button, active high, asynchronous to clk, may bounce
ped_served  input  1  from sequencer; high while the pedestrian green/blink phase is active
ped_req  output  1  pending pedestrian request to sequencer; registered, level
wait_lamp  output  1  WAIT indicator; high while a request is pending and unserved
btn_clean  output  1  debounced button level, for debug
req_count  output  8  number of accepted requests, saturating

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: sync flops=0, debounce counter=0, btn_clean=0, state=IDLE, pending=0, lockout counter=0, req_count=0. All outputs are therefore 0 during reset. Reset may assert in any state, mid-debounce or mid-lockout, and clears everything immediately.
- Synchroniser: btn_raw passes through two flops to produce btn_sync.
- Debounce:
  - The counter increments each cycle that btn_sync != btn_clean.
  - The counter clears to 0 on any cycle where they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the mismatch is still present, btn_clean <= btn_sync and the counter clears.
  - Latency: btn_clean rises DEBOUNCE_CYCLES+2 edges after the first edge that samples btn_raw=1, provided btn_raw stays high.
- Press event: internal signal, true on the same edge that btn_clean transitions 0->1. Releases (1->0) are not events.
- State machine states: IDLE, ARMED, SERVING, LOCKOUT.
  - IDLE: ped_req=0, wait_lamp=0. ped_served=1 -> SERVING (this takes priority over a simultaneous press, and req_count does not change). Otherwise press -> ARMED.
  - ARMED: ped_req=1, wait_lamp=1. Stays here until ped_served=1, then -> SERVING. Presses are ignored.
  - SERVING: ped_req=0, wait_lamp=0. Presses are ignored. ped_served=0 -> LOCKOUT, loading the lockout counter with LOCKOUT_CYCLES and clearing pending.
  - LOCKOUT:
    - ped_req=0 and wait_lamp=pending.
    - The lockout counter decrements each cycle.
    - A press sets pending.
    - ped_served=1 -> SERVING, pending cleared.
    - When the counter reaches 0, go to ARMED if pending, or if a press occurs on that same cycle; otherwise go to IDLE.
    - LOCKOUT therefore lasts exactly LOCKOUT_CYCLES cycles.
- Registered outputs: ped_req and wait_lamp are decoded from registered state and pending only, so they are glitch-free. ped_req asserts on the same edge that the state enters ARMED.
- req_count: increments by 1 on every transition into ARMED and saturates at 255.
- Request/acknowledge: the sequencer must observe ped_req=1 before ped_served clears the request. A ped_served pulse of one cycle is sufficient for the ARMED->SERVING transition.

Test Plan:
1. Reset. Bench uses DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8. Hold rst_n=0 for 3 cycles -> ped_req=0, wait_lamp=0, btn_clean=0, req_count=0. Next, drive the block into ARMED, then pulse rst_n=0 asynchronously between edges -> ped_req falls immediately, without waiting for a clock edge.
2. Clean press. btn_raw=1 held for 12 cycles -> btn_clean and ped_req both rise 6 edges after the first sampling edge; wait_lamp=1; req_count=1. Releasing the button leaves ped_req=1.
3. Bounce rejection. btn_raw toggles every 2 cycles for 30 cycles, then goes low -> btn_clean stays 0, ped_req stays 0, req_count stays 0.
4. Service and lockout. From ARMED, ped_served=1 for 5 cycles:
   - ped_req and wait_lamp fall on the first edge that samples ped_served=1.
   - When ped_served drops, the block is in LOCKOUT for 8 cycles, then IDLE.
   - req_count is unchanged.
5. Press during lockout. A clean press lands 2 cycles into LOCKOUT:
   - wait_lamp=1 from the press edge onward.
   - ped_req=0 until lockout expiry.
   - ped_req=1 exactly 8 cycles after LOCKOUT entry.
   - req_count increments by 1.
6. Simultaneous events and saturation.
   - In IDLE, press event and ped_served=1 on the same edge -> SERVING, ped_req never asserts, req_count unchanged.
   - Preload 255 accepted requests, then make another press -> req_count stays 255.

Source files
------------

// File: rtl/ped_request_ctrl.sv
// Pedestrian push-button front end: synchronises and debounces the button, latches one
// request for the crossing sequencer, drives the WAIT lamp and applies a post-walk lockout.
module ped_request_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       ped_served,
    output logic       ped_req,
    output logic       wait_lamp,
    output logic       btn_clean,
    output logic [7:0] req_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SERVING = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

    logic       sync1_q, sync2_q;
    logic [7:0] db_cnt_q, db_cnt_d;
    logic       clean_q, clean_d;
    logic       press;
    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [7:0] req_cnt_q, req_cnt_d;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // btn_clean follows btn_sync only after a run of DEBOUNCE_CYCLES disagreeing samples.
    always_comb begin
        db_cnt_d = 8'd0;
        clean_d  = clean_q;
        press    = 1'b0;
        if (sync2_q != clean_q) begin
            if (db_cnt_q == DB_LAST) begin
                clean_d = sync2_q;
                press   = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= 8'd0;
            clean_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            clean_q  <= clean_d;
        end
    end

    // State register, with the lockout counter, pending flag and request counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            lock_cnt_q <= 8'd0;
            req_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            lock_cnt_q <= lock_cnt_d;
            req_cnt_q  <= req_cnt_d;
        end
    end

    // Next-state logic; ped_served always wins over a simultaneous press.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ped_served)  state_d = SERVING;
                else if (press)  state_d = ARMED;
            end
            ARMED: begin
                if (ped_served)  state_d = SERVING;
            end
            SERVING: begin
                if (!ped_served) begin
                    state_d    = LOCKOUT;
                    lock_cnt_d = LOCK_LOAD;
                    pending_d  = 1'b0;
                end
            end
            LOCKOUT: begin
                lock_cnt_d = lock_cnt_q - 8'd1;
                if (ped_served) begin
                    state_d   = SERVING;
                    pending_d = 1'b0;
                end else if (lock_cnt_q <= 8'd1) begin
                    // Last lockout cycle: a press landing right now still counts.
                    state_d   = (pending_q || press) ? ARMED : IDLE;
                    pending_d = 1'b0;
                end else if (press) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        req_cnt_d = req_cnt_q;
        if (state_d == ARMED && state_q != ARMED && req_cnt_q != 8'hFF)
            req_cnt_d = req_cnt_q + 8'd1;
    end

    // Outputs decode registered state only, so they cannot glitch on input changes.
    always_comb begin
        ped_req   = (state_q == ARMED);
        wait_lamp = (state_q == ARMED) || (state_q == LOCKOUT && pending_q);
        btn_clean = clean_q;
        req_count = req_cnt_q;
    end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Self-checking bench for ped_request_ctrl: directed scenarios plus random button and
// service activity, all compared cycle by cycle against a behavioural model.
module tb_ped_request_ctrl;

    localparam int DB   = 4;
    localparam int LOCK = 8;

    localparam int M_IDLE    = 0;
    localparam int M_ARMED   = 1;
    localparam int M_SERVING = 2;
    localparam int M_LOCKOUT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic       ped_served;
    logic       ped_req;
    logic       wait_lamp;
    logic       btn_clean;
    logic [7:0] req_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: raw button history, debounced level, phase and bookkeeping.
    int m_hist1, m_hist2;
    int m_clean;
    int m_run;
    int m_mode;
    int m_elapsed;
    int m_pend;
    int m_count;

    ped_request_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .ped_served(ped_served),
        .ped_req   (ped_req),
        .wait_lamp (wait_lamp),
        .btn_clean (btn_clean),
        .req_count (req_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist1   = 0;
        m_hist2   = 0;
        m_clean   = 0;
        m_run     = 0;
        m_mode    = M_IDLE;
        m_elapsed = 0;
        m_pend    = 0;
        m_count   = 0;
    endtask

    task automatic accept();
        m_mode  = M_ARMED;
        m_count = (m_count < 255) ? m_count + 1 : 255;
    endtask

    task automatic model_step();
        int press;
        press = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_hist2 != m_clean) begin
            m_run++;
            if (m_run == DB) begin
                m_clean = m_hist2;
                m_run   = 0;
                press   = m_clean;
            end
        end else begin
            m_run = 0;
        end
        m_hist2 = m_hist1;
        m_hist1 = int'(btn_raw);

        case (m_mode)
            M_IDLE: begin
                if (ped_served)  m_mode = M_SERVING;
                else if (press != 0) accept();
            end
            M_ARMED: if (ped_served) m_mode = M_SERVING;
            M_SERVING: begin
                if (!ped_served) begin
                    m_mode    = M_LOCKOUT;
                    m_elapsed = 0;
                    m_pend    = 0;
                end
            end
            default: begin
                m_elapsed++;
                if (ped_served) begin
                    m_mode = M_SERVING;
                    m_pend = 0;
                end else begin
                    if (press != 0) m_pend = 1;
                    if (m_elapsed == LOCK) begin
                        if (m_pend != 0) accept();
                        else m_mode = M_IDLE;
                        m_pend = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("ped_req", ped_req, (m_mode == M_ARMED) ? 1 : 0);
        check("wait_lamp", wait_lamp,
              (m_mode == M_ARMED || (m_mode == M_LOCKOUT && m_pend != 0)) ? 1 : 0);
        check("btn_clean", btn_clean, m_clean);
        check("req_count", req_count, m_count);
    endtask

    task automatic press_release(input int hold);
        btn_raw = 1'b1;
        repeat (hold) tick();
        btn_raw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        int rise;
        int cnt_before;
        rst_n      = 1'b0;
        btn_raw    = 1'b0;
        ped_served = 1'b0;
        model_reset();

        // Reset values
        repeat (3) tick();
        check("rst_ped_req", ped_req, 0);
        check("rst_wait", wait_lamp, 0);
        check("rst_clean", btn_clean, 0);
        check("rst_count", req_count, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Clean press: latency of btn_clean and ped_req
        btn_raw = 1'b1;
        rise = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ped_req && rise == 0) rise = i;
            if (i == 6) check("clean_at_6", btn_clean, 1);
        end
        check("press_latency", rise, 6);
        check("press_wait", wait_lamp, 1);
        check("press_count", req_count, 1);
        btn_raw = 1'b0;
        repeat (8) tick();
        check("req_held_after_release", ped_req, 1);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check("async_ped_req", ped_req, 0);
        check("async_count", req_count, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Bounce rejection
        for (int i = 0; i < 30; i++) begin
            btn_raw = ((i / 2) % 2) != 0;
            tick();
        end
        btn_raw = 1'b0;
        repeat (10) tick();
        check("bounce_clean", btn_clean, 0);
        check("bounce_req", ped_req, 0);
        check("bounce_count", req_count, 0);

        // Service and lockout with no new press
        press_release(10);
        ped_served = 1'b1;
        tick();
        check("serve_req_drop", ped_req, 0);
        check("serve_wait_drop", wait_lamp, 0);
        repeat (4) tick();
        ped_served = 1'b0;
        repeat (12) tick();
        check("serve_count", req_count, 1);

        // Press landing two cycles into lockout
        press_release(10);
        ped_served = 1'b1;
        tick();
        tick();
        btn_raw = 1'b1;
        repeat (3) tick();
        ped_served = 1'b0;
        rise = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 2) check("lockout_wait_on_press", wait_lamp, 1);
            if (k == 7) check("lockout_req_low", ped_req, 0);
            if (ped_req && rise < 0) rise = k;
        end
        check("lockout_rearm_at", rise, LOCK);
        check("lockout_count", req_count, 3);
        btn_raw = 1'b0;
        ped_served = 1'b1;
        tick();
        ped_served = 1'b0;
        repeat (12) tick();

        // Press and ped_served on the same edge in IDLE
        cnt_before = int'(req_count);
        btn_raw = 1'b1;
        repeat (5) tick();
        ped_served = 1'b1;
        tick();
        check("simul_clean", btn_clean, 1);
        check("simul_req", ped_req, 0);
        tick();
        ped_served = 1'b0;
        btn_raw    = 1'b0;
        repeat (12) tick();
        check("simul_count", req_count, cnt_before);

        // Random button and service activity
        for (int s = 0; s < 200; s++) begin
            btn_raw    = $urandom_range(0, 1) != 0;
            ped_served = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 12)) tick();
        end
        ped_served = 1'b0;
        btn_raw    = 1'b0;
        repeat (20) tick();

        // Saturation of the request counter
        for (int r = 0; r < 260; r++) begin
            press_release($urandom_range(6, 10));
            ped_served = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            ped_served = 1'b0;
            repeat (9) tick();
        end
        check("sat_count", req_count, 255);
        press_release(8);
        check("sat_hold", req_count, 255);
        check("sat_armed", ped_req, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
